// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    REQ,
    RELEASE,
    FINISH
  } state_t;

  localparam int unsigned NUM_DENOM = 4;

  // Denomination indices; also the bit position in the coin_req one-hot.
  localparam int unsigned D10  = 0;
  localparam int unsigned D20  = 1;
  localparam int unsigned D50  = 2;
  localparam int unsigned D100 = 3;

  // Coin values in 10-sen units.
  localparam logic [3:0] UNIT_10  = 4'd1;
  localparam logic [3:0] UNIT_20  = 4'd2;
  localparam logic [3:0] UNIT_50  = 4'd5;
  localparam logic [3:0] UNIT_100 = 4'd10;

  // One-hot release codes.
  localparam logic [3:0] COIN_10  = 4'b0001;
  localparam logic [3:0] COIN_20  = 4'b0010;
  localparam logic [3:0] COIN_50  = 4'b0100;
  localparam logic [3:0] COIN_100 = 4'b1000;

  function automatic logic [3:0] coin_units(input logic [1:0] idx);
    case (idx)
      2'd0:    return UNIT_10;
      2'd1:    return UNIT_20;
      2'd2:    return UNIT_50;
      default: return UNIT_100;
    endcase
  endfunction

  function automatic logic [3:0] coin_code(input logic [1:0] idx);
    case (idx)
      2'd0:    return COIN_10;
      2'd1:    return COIN_20;
      2'd2:    return COIN_50;
      default: return COIN_100;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_money_add.sv
// Adds one coin (1/2/5/10 units) to a 2-digit BCD amount.
module bcd_money_add
  import change_dispenser_pkg::*;
(
  input  logic [3:0] msb,
  input  logic [3:0] lsb,
  input  logic [3:0] units,
  output logic [3:0] sum_msb,
  output logic [3:0] sum_lsb
);

  logic [4:0] lsb_sum;
  logic       carry;
  logic       whole_ringgit;

  // A 100-sen coin only touches the ringgit digit; others add into the LSB with carry.
  always_comb begin
    whole_ringgit = (units == UNIT_100);
    lsb_sum       = {1'b0, lsb} + (whole_ringgit ? 5'd0 : {1'b0, units});
    carry         = (lsb_sum >= 5'd10);
    sum_lsb       = carry ? 4'(lsb_sum - 5'd10) : lsb_sum[3:0];
    sum_msb       = msb + {3'b000, carry} + {3'b000, whole_ringgit};
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout: greedy stock-limited plan, then one coin per req/ack handshake.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned STOCK_W        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         change_MSB,
  input  logic [3:0]         change_LSB,
  input  logic [STOCK_W-1:0] stock_10,
  input  logic [STOCK_W-1:0] stock_20,
  input  logic [STOCK_W-1:0] stock_50,
  input  logic [STOCK_W-1:0] stock_100,
  input  logic               coin_ack,
  output logic [3:0]         coin_req,
  output logic [3:0]         paid_MSB,
  output logic [3:0]         paid_LSB,
  output logic               busy,
  output logic               done,
  output logic               err_nochange,
  output logic               err_bcd,
  output logic               err_jam
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t               state, state_next;
  logic [6:0]           remaining;
  logic [STOCK_W-1:0]   stock_in   [NUM_DENOM];
  logic [STOCK_W-1:0]   stock_left [NUM_DENOM];
  logic [STOCK_W-1:0]   plan_cnt   [NUM_DENOM];
  logic [TMR_W-1:0]     timer;
  logic [6:0]           total;
  logic                 digits_bad;
  logic                 timed_out;
  logic                 fit_found;
  logic [1:0]           fit_idx;
  logic                 any_plan;
  logic [1:0]           pay_idx;
  logic [3:0]           pay_units;
  logic [3:0]           sum_msb, sum_lsb;

  assign stock_in[D10]  = stock_10;
  assign stock_in[D20]  = stock_20;
  assign stock_in[D50]  = stock_50;
  assign stock_in[D100] = stock_100;

  assign total      = {change_MSB, 3'b000} + 7'({change_MSB, 1'b0}) + 7'(change_LSB);
  assign digits_bad = (change_MSB > 4'd9) || (change_LSB > 4'd9);
  assign timed_out  = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign pay_units  = coin_units(pay_idx);

  // Priority pick: ascending scan so the highest qualifying denomination wins.
  always_comb begin
    fit_found = 1'b0;
    fit_idx   = '0;
    any_plan  = 1'b0;
    pay_idx   = '0;
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      if (stock_left[i] != '0 && {3'b000, coin_units(2'(i))} <= remaining) begin
        fit_found = 1'b1;
        fit_idx   = 2'(i);
      end
      if (plan_cnt[i] != '0) begin
        any_plan = 1'b1;
        pay_idx  = 2'(i);
      end
    end
  end

  bcd_money_add u_add (
    .msb     (paid_MSB),
    .lsb     (paid_LSB),
    .units   (pay_units),
    .sum_msb (sum_msb),
    .sum_lsb (sum_lsb)
  );

  // State register; async reset also drops coin_req since it decodes from state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    coin_req   = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = digits_bad ? FINISH : PLAN;
      PLAN:    if (!fit_found) state_next = (remaining == '0 && any_plan) ? REQ : FINISH;
      REQ: begin
        coin_req = coin_code(pay_idx);
        if (coin_ack)       state_next = RELEASE;
        else if (timed_out) state_next = FINISH;
      end
      RELEASE: begin
        if (!coin_ack)      state_next = any_plan ? REQ : FINISH;
        else if (timed_out) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Plan counters, stock copies, timeout counter, paid total and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining    <= '0;
      timer        <= '0;
      paid_MSB     <= '0;
      paid_LSB     <= '0;
      done         <= 1'b0;
      err_nochange <= 1'b0;
      err_bcd      <= 1'b0;
      err_jam      <= 1'b0;
      for (int unsigned i = 0; i < NUM_DENOM; i++) begin
        stock_left[i] <= '0;
        plan_cnt[i]   <= '0;
      end
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            remaining    <= digits_bad ? 7'd0 : total;
            paid_MSB     <= '0;
            paid_LSB     <= '0;
            err_nochange <= 1'b0;
            err_jam      <= 1'b0;
            err_bcd      <= digits_bad;
            for (int unsigned i = 0; i < NUM_DENOM; i++) begin
              stock_left[i] <= stock_in[i];
              plan_cnt[i]   <= '0;
            end
          end
        end
        PLAN: begin
          timer <= '0;
          if (fit_found) begin
            plan_cnt[fit_idx]   <= plan_cnt[fit_idx] + STOCK_W'(1);
            stock_left[fit_idx] <= stock_left[fit_idx] - STOCK_W'(1);
            remaining           <= remaining - {3'b000, coin_units(fit_idx)};
          end else if (remaining != '0) begin
            err_nochange <= 1'b1;
          end
        end
        REQ: begin
          if (coin_ack) begin
            plan_cnt[pay_idx] <= plan_cnt[pay_idx] - STOCK_W'(1);
            paid_MSB          <= sum_msb;
            paid_LSB          <= sum_lsb;
            timer             <= '0;
          end else if (timed_out) begin
            err_jam <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RELEASE: begin
          if (!coin_ack)      timer   <= '0;
          else if (timed_out) err_jam <= 1'b1;
          else                timer   <= timer + TMR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: coin sequence and end-of-transaction results.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] change_MSB, change_LSB;
  logic [3:0] stock_10, stock_20, stock_50, stock_100;
  logic       coin_ack;
  logic [3:0] coin_req, paid_MSB, paid_LSB;
  logic       busy, done, err_nochange, err_bcd, err_jam;

  typedef struct {
    int pm;
    int pl;
    int nc;
    int bcd;
    int jam;
  } res_t;

  int   exp_coin[$];
  res_t exp_res[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   res_expected = 0;
  int   coins_seen = 0;
  bit   ack_en = 1'b1;
  int   ack_delay = 2;
  int   ack_cnt = 0;

  change_dispenser #(.STOCK_W(4), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset_n),
    .start        (start),
    .change_MSB   (change_MSB),
    .change_LSB   (change_LSB),
    .stock_10     (stock_10),
    .stock_20     (stock_20),
    .stock_50     (stock_50),
    .stock_100    (stock_100),
    .coin_ack     (coin_ack),
    .coin_req     (coin_req),
    .paid_MSB     (paid_MSB),
    .paid_LSB     (paid_LSB),
    .busy         (busy),
    .done         (done),
    .err_nochange (err_nochange),
    .err_bcd      (err_bcd),
    .err_jam      (err_jam)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent greedy model: expected coin order and final result.
  task automatic model_push(input int msb, input int lsb, input int s10, input int s20,
                            input int s50, input int s100);
    int   val[4];
    int   st[4];
    int   cnt[4];
    int   rem;
    res_t r;
    val = '{1, 2, 5, 10};
    st  = '{s10, s20, s50, s100};
    r   = '{default: 0};
    if (msb > 9 || lsb > 9) begin
      r.bcd = 1;
    end else begin
      rem = msb * 10 + lsb;
      for (int d = 3; d >= 0; d--) begin
        cnt[d] = 0;
        while (rem >= val[d] && st[d] > 0) begin
          cnt[d]++;
          st[d]--;
          rem -= val[d];
        end
      end
      if (rem != 0) begin
        r.nc = 1;
      end else begin
        for (int d = 3; d >= 0; d--)
          for (int k = 0; k < cnt[d]; k++) exp_coin.push_back(1 << d);
        r.pm = (msb * 10 + lsb) / 10;
        r.pl = (msb * 10 + lsb) % 10;
      end
    end
    exp_res.push_back(r);
    res_expected++;
  endtask

  task automatic drive_inputs(input int msb, input int lsb, input int s10, input int s20,
                              input int s50, input int s100);
    change_MSB = 4'(msb);
    change_LSB = 4'(lsb);
    stock_10   = 4'(s10);
    stock_20   = 4'(s20);
    stock_50   = 4'(s50);
    stock_100  = 4'(s100);
  endtask

  // Pulse start and watch until done; optionally poke start while busy.
  task automatic run_start(input int msb, input int lsb, input int s10, input int s20,
                           input int s50, input int s100, input bit poke,
                           output int done_at, output int busy_cyc, output int req_cyc);
    @(negedge clk);
    drive_inputs(msb, lsb, s10, s20, s50, s100);
    start    = 1'b1;
    done_at  = 0;
    busy_cyc = 0;
    req_cyc  = 0;
    for (int i = 1; i <= 400 && done_at == 0; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      drive_inputs(msb, lsb, s10, s20, s50, s100);
      if (busy) busy_cyc++;
      if (coin_req != '0) req_cyc++;
      if (done) done_at = i;
      if (poke && (i == 4 || i == 9) && busy) begin
        change_LSB = 4'hA;
        start      = 1'b1;
      end
    end
    check_eq("done_seen", (done_at > 0) ? 1 : 0, 1);
  endtask

  // Mechanism model: acks after ack_delay cycles of coin_req, releases when req drops.
  initial begin
    coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (coin_ack) begin
        if (coin_req == '0) coin_ack = 1'b0;
      end else if (ack_en && coin_req != '0) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          coin_ack = 1'b1;
          ack_cnt  = 0;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Output monitor: pops the scoreboard on each new coin request and on done.
  initial begin
    logic [3:0] prev_req;
    res_t       r;
    int         e;
    prev_req = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        prev_req = '0;
      end else begin
        if (coin_req != '0) begin
          check_eq("req_onehot", int'($onehot(coin_req)), 1);
          if (prev_req == '0) begin
            coins_seen++;
            check_eq("req_expected", (exp_coin.size() > 0) ? 1 : 0, 1);
            if (exp_coin.size() > 0) begin
              e = exp_coin.pop_front();
              check_eq("coin_req", int'(coin_req), e);
            end
          end
        end
        prev_req = coin_req;
        if (done) begin
          done_cnt++;
          check_eq("done_expected", (exp_res.size() > 0) ? 1 : 0, 1);
          if (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            check_eq("paid_MSB", int'(paid_MSB), r.pm);
            check_eq("paid_LSB", int'(paid_LSB), r.pl);
            check_eq("err_nochange", int'(err_nochange), r.nc);
            check_eq("err_bcd", int'(err_bcd), r.bcd);
            check_eq("err_jam", int'(err_jam), r.jam);
          end
        end
      end
    end
  end

  initial begin
    int   done_at, busy_cyc, req_cyc, base;
    res_t r;
    reset_n = 1'b0;
    start   = 1'b0;
    drive_inputs(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_coin_req", int'(coin_req), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_paid", int'({paid_MSB, paid_LSB}), 0);
    check_eq("rst_errs", int'({err_nochange, err_bcd, err_jam}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1.80 with full stock, extra start pulses while busy must be ignored.
    model_push(1, 8, 5, 5, 5, 5);
    run_start(1, 8, 5, 5, 5, 5, 1'b1, done_at, busy_cyc, req_cyc);

    // 0.60 with no 10-sen coins: greedy takes 50 and strands 10.
    model_push(0, 6, 0, 5, 5, 0);
    run_start(0, 6, 0, 5, 5, 0, 1'b0, done_at, busy_cyc, req_cyc);
    check_eq("nochange_req_cycles", req_cyc, 0);

    // Zero amount: done three cycles after start, busy for two.
    model_push(0, 0, 5, 5, 5, 5);
    run_start(0, 0, 5, 5, 5, 5, 1'b0, done_at, busy_cyc, req_cyc);
    check_eq("zero_done_at", done_at, 3);
    check_eq("zero_busy_cycles", busy_cyc, 2);
    check_eq("zero_req_cycles", req_cyc, 0);

    // 9.90 with mixed stock: BCD carries on the paid total.
    model_push(9, 9, 0, 2, 1, 9);
    run_start(9, 9, 0, 2, 1, 9, 1'b0, done_at, busy_cyc, req_cyc);

    // 0.90 with limited stock.
    model_push(0, 9, 5, 2, 1, 0);
    run_start(0, 9, 5, 2, 1, 0, 1'b0, done_at, busy_cyc, req_cyc);

    // Jam: mechanism never acks; request held for the full timeout.
    ack_en = 1'b0;
    exp_coin.push_back(8);
    r = '{default: 0};
    r.jam = 1;
    exp_res.push_back(r);
    res_expected++;
    run_start(1, 0, 5, 5, 5, 5, 1'b0, done_at, busy_cyc, req_cyc);
    check_eq("jam_req_cycles", req_cyc, 16);
    check_eq("jam_req_after", int'(coin_req), 0);
    ack_en = 1'b1;

    // Bad BCD digit: straight to FINISH.
    model_push(0, 10, 5, 5, 5, 5);
    run_start(0, 10, 5, 5, 5, 5, 1'b0, done_at, busy_cyc, req_cyc);
    check_eq("bcd_done_at", done_at, 2);
    check_eq("bcd_busy_cycles", busy_cyc, 1);

    // Reset during the second REQ of a 0.40 payout.
    model_push(0, 4, 0, 3, 0, 0);
    base = coins_seen;
    @(negedge clk);
    drive_inputs(0, 4, 0, 3, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && coins_seen < base + 2; i++) begin
      @(posedge clk);
      #2;
    end
    check_eq("second_req_seen", coins_seen - base, 2);
    check_eq("second_req_high", (coin_req != '0) ? 1 : 0, 1);
    reset_n = 1'b0;
    #1;
    check_eq("async_req_drop", int'(coin_req), 0);
    check_eq("async_busy_drop", int'(busy), 0);
    exp_res.delete();
    res_expected--;
    repeat (2) @(posedge clk);
    #1;
    check_eq("post_rst_outputs",
             int'({coin_req, paid_MSB, paid_LSB, busy, done, err_nochange, err_bcd, err_jam}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_push(0, 4, 0, 3, 0, 0);
    run_start(0, 4, 0, 3, 0, 0, 1'b0, done_at, busy_cyc, req_cyc);

    repeat (5) @(posedge clk);
    #2;
    check_eq("coin_queue_empty", exp_coin.size(), 0);
    check_eq("res_queue_empty", exp_res.size(), 0);
    check_eq("done_count", done_cnt, res_expected);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout side of the vending coin path: takes the change owed as a 2-digit BCD amount and drives the coin-release mechanism.
- Coin denominations are 10, 20, 50 and 100 sen.
- Runs a greedy, stock-limited payout plan first. Dispenses only if exact change is possible, one coin per four-phase req/ack handshake.
- Sits after the control block, fed by its change result and the per-denomination stock counts.

Parameters:
- STOCK_W, 4, width of stock inputs and plan counters.
- TIMEOUT_CYCLES, 255, maximum cycles coin_req may wait for coin_ack before a jam is declared.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to pay change; sampled only in IDLE.
- change_MSB  in  4  BCD ringgit digit, 0-9.
- change_LSB  in  4  BCD 10-sen digit, 0-9.
- stock_10, stock_20, stock_50, stock_100  in  STOCK_W each  coins available; sampled on accepted start.
- coin_ack  in  1  mechanism acknowledge: high = coin released.
- coin_req  out  4  one-hot release request; bit3 = 100, bit2 = 50, bit1 = 20, bit0 = 10.
- paid_MSB, paid_LSB  out  4 each  BCD running total dispensed this transaction.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at the end of every transaction.
- err_nochange  out  1  exact change impossible with current stock.
- err_bcd  out  1  change digit greater than 9.
- err_jam  out  1  handshake timeout.

Behaviour:
- Reset (async, reset = 0): state IDLE; coin_req, paid, busy, done and all err outputs = 0; plan counters cleared.
- Reset mid-transaction drops coin_req immediately, without waiting for a clock edge.
- Amounts are held internally in binary 10-sen units: total = MSB*10 + LSB, range 0-99, 7 bits. Coin values are 10/5/2/1 units.
- Errors are sticky and are cleared only by the next accepted start.
- States: IDLE, PLAN, REQ, RELEASE, FINISH.
- IDLE:
  - start = 1 latches the amount and stock, clears paid and errors, then enters PLAN.
  - If either digit is greater than 9: set err_bcd and go to FINISH.
  - start while busy is ignored.
- PLAN: one coin planned per cycle. Pick the highest denomination with remaining >= value and stock_left > 0; then increment that plan count, decrement its stock_left, and subtract its value from remaining.
  - If no coin fits and remaining = 0: go to REQ, or to FINISH if no coins were planned.
  - If no coin fits and remaining > 0: set err_nochange and go to FINISH. No coin is dispensed.
  - The algorithm is greedy with no backtracking. This limitation is documented and intended.
- REQ:
  - Drive coin_req one-hot for the highest denomination with a nonzero plan count, and start the timeout counter.
  - coin_ack = 1: drop coin_req next cycle, decrement that plan count, add its value to paid (BCD add), go to RELEASE.
  - Timeout reached: set err_jam, coin_req = 0, go to FINISH.
- RELEASE:
  - Wait for coin_ack = 0, with the same timeout and jam rule.
  - Then go to REQ if any plan count is nonzero, otherwise FINISH.
- FINISH: pulse done for 1 cycle, then IDLE. paid and err hold their values until the next start.
- Handshake rules:
  - coin_req changes only when coin_ack matches the current phase.
  - coin_ack while in IDLE or PLAN is ignored.
  - At most one coin_req bit is ever high.
- Latency: a zero amount pulses done 3 cycles after start (PLAN, FINISH). PLAN takes N+1 cycles for N planned coins.
- paid can never exceed the change amount, so no BCD overflow occurs.

Decomposition:
- Shared package holds:
  - state enum;
  - denomination index constants D10 = 0, D20 = 1, D50 = 2, D100 = 3;
  - unit values 1/2/5/10;
  - one-hot coin codes.
- One sub-module, bcd_money_add: adds a coin value (1/2/5/10 units) to a 2-digit BCD value, combinationally, with carry from LSB to MSB.

Test Plan:
1. Change 1.80, all stock 5, ack after 2 cycles -> coin_req sequence 1000, 0100, 0010, 0001; paid 1/8; done pulse; no errors.
2. Change 0.60, stock_10 = 0, stock_20 = 5, stock_50 = 5, stock_100 = 0 -> err_nochange = 1; coin_req never asserted; paid 0/0; done pulses.
3. Change 0.00 -> done exactly 3 cycles after start; coin_req stays 0; busy high for 2 cycles.
4. TIMEOUT_CYCLES = 16, change 1.00, coin_ack held 0 -> err_jam after 16 cycles in REQ; coin_req returns to 0; done pulses; paid 0/0.
5. Change 0.40, stock_20 = 3; assert reset low during the second REQ -> coin_req drops asynchronously; all outputs are 0 after release; a new start works normally.
6. change_LSB = 4'hA -> err_bcd = 1, no PLAN cycles, done pulses; start pulses while busy (case 1) are ignored.
